// File: rtl/decoder_3_8_stream.sv
// Streaming 3-to-8 one-hot decoder: a small input FIFO feeds a registered output
// stage under valid/ready handshakes on both sides.
module decoder_3_8_stream #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  input  logic       in_none,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] y,
  output logic       out_none,
  output logic [3:0] level
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_LVL = 4'(DEPTH);

  logic [3:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       y_q, y_d;
  logic             out_none_q, out_none_d;
  logic             push, pop;
  logic [3:0]       head;

  function automatic logic [7:0] decode_line(input logic none, input logic [2:0] idx);
    if (none) return 8'h00;
    return 8'h01 << idx;
  endfunction

  // in_ready depends only on registered occupancy, so a same-cycle pop never raises it.
  assign in_ready = (level_q != FULL_LVL) && rst_n;
  assign push     = in_valid && in_ready;
  assign pop      = (level_q != 4'd0) && (!out_valid_q || out_ready);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    out_none_d  = out_none_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase

    if (pop) begin
      out_valid_d = 1'b1;
      y_d         = decode_line(head[3], head[2:0]);
      out_none_d  = head[3];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= 4'd0;
      out_valid_q <= 1'b0;
      y_q         <= 8'h00;
      out_none_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_none_q  <= out_none_d;
    end
  end

  // Storage is left unreset; pointers and level gate every observable read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_none, code};
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_none  = out_none_q;
  assign level     = level_q;

endmodule

// File: tb/tb_decoder_3_8_stream.sv
// Bench for decoder_3_8_stream: directed scenarios plus random traffic, checked
// against a queue-based reference model of the FIFO and output slot.
module tb_decoder_3_8_stream;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] code = 3'd0;
  logic       in_none = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic       out_none;
  logic [3:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of accepted words plus the output slot.
  logic [3:0] mq[$];
  bit         m_vld  = 1'b0;
  logic [7:0] m_y    = 8'h00;
  bit         m_none = 1'b0;

  decoder_3_8_stream #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .in_none(in_none), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_none(out_none), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit [2:0] c, input bit n, input bit r, input bit rs);
    bit         exp_ready;
    bit         acc;
    bit         take;
    logic [3:0] w;
    in_valid  = v;
    code      = c;
    in_none   = n;
    out_ready = r;
    rst_n     = rs;
    #1;
    exp_ready = rs && (mq.size() != DEPTH);
    check("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (!rs) begin
      mq.delete();
      m_vld = 0; m_y = 8'h00; m_none = 0;
    end else begin
      acc  = v && exp_ready;
      take = (mq.size() > 0) && (!m_vld || r);
      if (take) begin
        w      = mq.pop_front();
        m_vld  = 1;
        m_none = w[3];
        m_y    = w[3] ? 8'h00 : 8'(2 ** int'(w[2:0]));
      end else if (m_vld && r) begin
        m_vld = 0;
      end
      if (acc) mq.push_back({n, c});
    end
    #1;
    check("out_valid", out_valid, m_vld);
    check("level", level, mq.size());
    if (m_vld || !rs) begin
      check("y", y, m_y);
      check("out_none", out_none, m_none);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_level", level, 0);

    // Single word
    step(1, 3'b101, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check("single_y", y, 8'h20);
    check("single_vld", out_valid, 1);
    step(0, 0, 0, 1, 1);

    // Full sweep, back-to-back
    for (int i = 0; i < 8; i++) step(1, 3'(i), 0, 1, 1);
    check("sweep_last_y", y, 8'h40);
    step(0, 0, 0, 1, 1);
    check("sweep_end_y", y, 8'h80);
    step(0, 0, 0, 1, 1);

    // None word ignores code
    step(1, 3'b111, 1, 1, 1);
    step(0, 0, 0, 1, 1);
    check("none_y", y, 8'h00);
    check("none_flag", out_none, 1);
    step(0, 0, 0, 1, 1);

    // Backpressure and pointer wrap
    step(1, 3'd1, 0, 0, 1);
    step(1, 3'd2, 0, 0, 1);
    step(1, 3'd3, 0, 0, 1);
    check("bp_level", level, 2);
    check("bp_hold", y, 8'h02);
    step(1, 3'd4, 0, 0, 1);
    check("bp_hold2", y, 8'h02);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // Simultaneous push/pop at level 1
    step(1, 3'd5, 0, 0, 1);
    step(1, 3'd6, 0, 0, 1);
    check("pp_pre_level", level, 1);
    step(1, 3'd7, 0, 1, 1);
    check("pp_level", level, 1);
    check("pp_y", y, 8'h40);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);

    // Mid-operation reset
    step(1, 3'd0, 0, 0, 1);
    step(1, 3'd1, 0, 0, 1);
    step(1, 3'd2, 0, 0, 1);
    check("mr_pre_level", level, 2);
    step(0, 0, 0, 0, 0);
    check("mr_vld", out_valid, 0);
    check("mr_y", y, 8'h00);
    check("mr_level", level, 0);
    step(0, 0, 0, 1, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) != 0, 3'($urandom_range(7)), $urandom_range(7) == 0,
           $urandom_range(2) != 0, $urandom_range(63) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_3_8_stream.md
DECODER_3_8_STREAM -- requirements
Module: decoder_3_8_stream

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, which sets the input FIFO entry count; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream code word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 SHALL have port code, input, 3 bits: binary index, MSB first, of the line to assert.
REQ-007 SHALL have port in_none, input, 1 bit: no line is active; code is ignored.
REQ-008 SHALL have port out_valid, output, 1 bit: y and out_none hold a decoded word.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumes the word.
REQ-010 SHALL have port y, output, 8 bits: one-hot decoded lines, y[7] MSB.
REQ-011 SHALL have port out_none, output, 1 bit: the decoded word is the "no line" word.
REQ-012 SHALL have port level, output, 4 bits: FIFO occupancy, 0..DEPTH, excluding the output register.

Function
REQ-013 SHALL accept a word when in_valid=1 and in_ready=1 at a rising edge, writing {in_none, code} into the FIFO tail.
REQ-014 SHALL drive in_ready = (level != DEPTH) && rst_n, from registered state only, with no combinational path from out_ready.
REQ-015 SHALL, when the FIFO is full, deassert in_ready; a pop in the same cycle SHALL raise in_ready only from the next cycle.
REQ-016 SHALL use read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 SHALL load the output register from the FIFO head at an edge where level>0 and (out_valid=0 or out_ready=1), popping the head in that edge.
REQ-018 SHALL clear out_valid at an edge where out_valid=1, out_ready=1 and level=0.
REQ-019 SHALL hold y, out_none and out_valid unchanged while out_valid=1 and out_ready=0.
REQ-020 SHALL, on load, set y = 8'b1 << code and out_none=0 when the stored none bit is 0.
REQ-021 SHALL, on load, set y = 8'h00 and out_none=1 when the stored none bit is 1, irrespective of code.
REQ-022 SHALL have a minimum latency of 2 edges: a push at edge N with an empty FIFO and an idle output gives out_valid=1 after edge N+1.
REQ-023 SHALL, on a simultaneous push and pop, leave level unchanged and keep both words in order.
REQ-024 SHALL sustain one word per cycle when out_ready is held at 1 and in_valid is held at 1.
REQ-025 SHALL never reorder, drop or duplicate accepted words.
REQ-026 SHALL update level as +1 on push only, -1 on pop only, and leave it unchanged on both or neither.

Reset
REQ-027 SHALL, at a rising edge with rst_n=0, set level=0, both pointers=0, out_valid=0, y=8'h00 and out_none=0.
REQ-028 SHALL, while rst_n=0, ignore in_valid and out_ready and discard all in-flight words, including a word held in the output register.
REQ-029 SHALL leave FIFO storage contents don't-care after reset; they SHALL be unobservable at the outputs.

Verification
REQ-030 SHALL be covered by this single-word scenario: reset, then push code=3'b101 with in_none=0 and out_ready=1 -> after 2 edges out_valid=1, y=8'b0010_0000, out_none=0.
REQ-031 SHALL be covered by this full-sweep scenario: push codes 0..7 back-to-back with out_ready=1 -> y sequence 8'h01, 8'h02, 8'h04 ... 8'h80, one per cycle, with no gaps after the first.
REQ-032 SHALL be covered by this none scenario: push in_none=1 with code=3'b111 -> y=8'h00 and out_none=1.
REQ-033 SHALL be covered by this backpressure and wrap scenario: with DEPTH=2 and out_ready=0, push 3 words -> in_ready=0 after the FIFO fills and level=2; the first word is held stable in the output; then release out_ready -> words emerge in order and pointers wrap.
REQ-034 SHALL be covered by this simultaneous push/pop scenario: with level=1 and out_valid=1, push and consume in the same cycle -> level remains 1 and ordering is preserved.
REQ-035 SHALL be covered by this mid-operation reset scenario: with level=2 and out_valid=1, assert rst_n=0 for one edge -> out_valid=0, y=8'h00, level=0, in_ready=1 on the first cycle after reset is released.
